// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with an in-order prefetch buffer.
// Keeps up to FIFO_DEPTH AXI reads outstanding and buffers the returned
// words with their PCs for the IDU. A redirect flushes the buffer and
// discards in-flight responses. A bad response becomes a faulting entry,
// and fetching then stops until the next redirect.
module ifu_prefetch #(
  parameter int                  DATA_LEN   = 32,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [DATA_LEN-1:0] RST_PC     = 32'h80000000,
  parameter logic [DATA_LEN-1:0] NOP_INST   = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Jump_flag,
  input  logic [DATA_LEN-1:0] Jump_PC,
  output logic                arvalid,
  input  logic                arready,
  output logic [DATA_LEN-1:0] PC_to_sram,
  input  logic [DATA_LEN-1:0] inst_in,
  input  logic                rvalid,
  input  logic [2:0]          rresp,
  output logic                rready,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [DATA_LEN-1:0] inst_fetch,
  output logic [DATA_LEN-1:0] PC_now,
  output logic                inst_fault
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [DATA_LEN-1:0] PC_STEP = DATA_LEN'(4);

  localparam logic [1:0] AR_IDLE = 2'd0;
  localparam logic [1:0] AR_WAIT = 2'd1;
  localparam logic [1:0] AR_HALT = 2'd2;

  // AR channel control
  logic [1:0]          ar_state_q, ar_state_d;
  logic                arvalid_q, arvalid_d;
  logic [DATA_LEN-1:0] araddr_q, araddr_d;
  // fetch_pc is the address the next issued AR will carry
  logic [DATA_LEN-1:0] fetch_pc_q, fetch_pc_d;

  // Occupancy bookkeeping
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] stale_q, stale_d;

  // Prefetch buffer
  logic [DATA_LEN-1:0] buf_inst_q  [FIFO_DEPTH];
  logic [DATA_LEN-1:0] buf_pc_q    [FIFO_DEPTH];
  logic                buf_fault_q [FIFO_DEPTH];
  logic [PW-1:0]       buf_wr_q, buf_wr_d;
  logic [PW-1:0]       buf_rd_q, buf_rd_d;

  // PCs of accepted ARs awaiting their R beat
  logic [DATA_LEN-1:0] pcq_q [FIFO_DEPTH];
  logic [PW-1:0]       pcq_wr_q, pcq_wr_d;
  logic [PW-1:0]       pcq_rd_q, pcq_rd_d;

  logic          ar_hs;
  logic          r_fire;
  logic          r_drop;
  logic          r_push;
  logic          r_fault;
  logic          head_vld;
  logic          pop;
  logic [CW-1:0] infl_after_r;
  logic          credit_now;
  logic          credit_next;
  logic [DATA_LEN-1:0] push_inst;

  assign ar_hs        = arvalid_q & arready;
  // A beat with nothing outstanding is a protocol error and is ignored.
  assign r_fire       = rvalid & (inflight_q != '0);
  assign r_drop       = r_fire & (Jump_flag | (stale_q != '0));
  assign r_push       = r_fire & ~r_drop;
  assign r_fault      = r_push & (rresp != 3'b000);
  assign head_vld     = (count_q != '0);
  assign pop          = head_vld & inst_ready & ~Jump_flag;
  assign infl_after_r = inflight_q - CW'(r_fire);
  assign push_inst    = r_fault ? NOP_INST : inst_in;

  // Space is reserved when an AR is issued, so credit covers both
  // buffered entries and reads not yet returned.
  assign credit_now  = ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_W;
  assign credit_next = ({1'b0, count_d} + {1'b0, infl_after_r}) < DEPTH_W;

  // Buffer occupancy and pointer next-state
  always_comb begin
    count_d  = count_q + CW'(r_push) - CW'(pop);
    buf_wr_d = buf_wr_q + PW'(r_push);
    buf_rd_d = buf_rd_q + PW'(pop);
    pcq_wr_d = pcq_wr_q + PW'(ar_hs);
    pcq_rd_d = pcq_rd_q + PW'(r_fire);
    if (Jump_flag) begin
      count_d  = '0;
      buf_rd_d = buf_wr_q;
    end
  end

  // AR issue FSM, in-flight and stale accounting
  always_comb begin
    ar_state_d = ar_state_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = infl_after_r;
    stale_d    = stale_q - CW'(r_fire && (stale_q != '0));
    if (Jump_flag) begin
      // Everything still outstanding, including a held AR, is now stale.
      stale_d    = infl_after_r;
      fetch_pc_d = Jump_PC;
      arvalid_d  = arvalid_q & ~arready;
      ar_state_d = (arvalid_q & ~arready) ? AR_WAIT : AR_IDLE;
    end else if (r_fault) begin
      stale_d    = infl_after_r;
      arvalid_d  = arvalid_q & ~arready;
      ar_state_d = AR_HALT;
    end else begin
      case (ar_state_q)
        AR_IDLE: begin
          if (credit_now) begin
            arvalid_d  = 1'b1;
            araddr_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            inflight_d = infl_after_r + CW'(1);
            ar_state_d = AR_WAIT;
          end
        end
        AR_WAIT: begin
          if (ar_hs) begin
            if (credit_next) begin
              araddr_d   = fetch_pc_q;
              fetch_pc_d = fetch_pc_q + PC_STEP;
              inflight_d = infl_after_r + CW'(1);
            end else begin
              arvalid_d  = 1'b0;
              ar_state_d = AR_IDLE;
            end
          end
        end
        AR_HALT: begin
          // A request already presented must still complete.
          arvalid_d = arvalid_q & ~arready;
        end
        default: begin
          arvalid_d  = 1'b0;
          ar_state_d = AR_IDLE;
        end
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_state_q <= AR_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= RST_PC;
      fetch_pc_q <= RST_PC;
      count_q    <= '0;
      inflight_q <= '0;
      stale_q    <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
    end else begin
      ar_state_q <= ar_state_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
    end
  end

  // Buffer and PC-queue storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_inst_q[i]  <= NOP_INST;
        buf_pc_q[i]    <= RST_PC;
        buf_fault_q[i] <= 1'b0;
        pcq_q[i]       <= RST_PC;
      end
    end else begin
      if (r_push) begin
        buf_inst_q[buf_wr_q]  <= push_inst;
        buf_pc_q[buf_wr_q]    <= pcq_q[pcq_rd_q];
        buf_fault_q[buf_wr_q] <= r_fault;
      end
      if (ar_hs) begin
        pcq_q[pcq_wr_q] <= araddr_q;
      end
    end
  end

  // A read beat with nothing outstanding is a protocol violation.
  always @(posedge clk) begin
    if (rst_n && rvalid) begin
      assert (inflight_q != '0);
    end
  end

  assign arvalid    = arvalid_q;
  assign PC_to_sram = araddr_q;
  assign rready     = 1'b1;
  assign inst_valid = head_vld;
  assign inst_fetch = head_vld ? buf_inst_q[buf_rd_q] : NOP_INST;
  assign PC_now     = buf_pc_q[buf_rd_q];
  assign inst_fault = head_vld & buf_fault_q[buf_rd_q];

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed testbench for ifu_prefetch with a small in-order SRAM responder.
module tb_ifu_prefetch;

  localparam logic [31:0] RST_PC = 32'h80000000;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] JPC    = 32'h80001000;

  logic        clk;
  logic        rst_n;
  logic        Jump_flag;
  logic [31:0] Jump_PC;
  logic        arvalid;
  logic        arready;
  logic [31:0] PC_to_sram;
  logic [31:0] inst_in;
  logic        rvalid;
  logic [2:0]  rresp;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_fetch;
  logic [31:0] PC_now;
  logic        inst_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] rq[$];
  logic        resp_en;
  logic        fault_en;
  logic [31:0] fault_addr;
  int          hs_total;
  logic [31:0] last_hs_addr;

  ifu_prefetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Jump_flag  (Jump_flag),
    .Jump_PC    (Jump_PC),
    .arvalid    (arvalid),
    .arready    (arready),
    .PC_to_sram (PC_to_sram),
    .inst_in    (inst_in),
    .rvalid     (rvalid),
    .rresp      (rresp),
    .rready     (rready),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_fetch (inst_fetch),
    .PC_now     (PC_now),
    .inst_fault (inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // One clock; the responder returns each accepted AR one cycle later.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    logic [31:0] r;
    hs = arvalid && arready;
    a  = PC_to_sram;
    @(posedge clk);
    #1;
    if (hs) begin
      rq.push_back(a);
      hs_total++;
      last_hs_addr = a;
    end
    if (resp_en && rq.size() > 0) begin
      r       = rq.pop_front();
      rvalid  = 1'b1;
      inst_in = inst_of(r);
      rresp   = (fault_en && r == fault_addr) ? 3'b010 : 3'b000;
    end else begin
      rvalid = 1'b0;
      rresp  = 3'b000;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    Jump_flag = 1'b0;
    rvalid    = 1'b0;
    rresp     = 3'b000;
    rq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    hs_total = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Jump_flag = 1'b0; Jump_PC = '0; arready = 1'b1;
    inst_in = '0; rvalid = 1'b0; rresp = 3'b000; inst_ready = 1'b1;
    resp_en = 1'b1; fault_en = 1'b0; fault_addr = '0; hs_total = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
    checks++; if (PC_to_sram !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", PC_to_sram, RST_PC); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    checks++; if (inst_fetch !== NOP) begin errors++; $display("FAIL reset_fetch: got %h want %h", inst_fetch, NOP); end
    checks++; if (PC_now !== RST_PC) begin errors++; $display("FAIL reset_pcnow: got %h want %h", PC_now, RST_PC); end
    checks++; if (inst_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", inst_fault); end
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rready: got %b want 1", rready); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    int ndeliv;
    arready = 1'b1; inst_ready = 1'b1; resp_en = 1'b1; fault_en = 1'b0;
    do_reset();
    exp_pc = RST_PC; ndeliv = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (arvalid !== 1'b1 || PC_to_sram !== RST_PC + 32'(4 * i)) begin
        errors++; $display("FAIL stream_ar[%0d]: got %b/%h want 1/%h", i, arvalid, PC_to_sram, RST_PC + 32'(4 * i));
      end
      if (i == 2) begin
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_latency: got %b want 1", inst_valid); end
      end
      if (inst_valid) begin
        checks++;
        if (PC_now !== exp_pc || inst_fetch !== inst_of(exp_pc) || inst_fault !== 1'b0) begin
          errors++; $display("FAIL stream_head: got %h/%h/%b want %h/%h/0", PC_now, inst_fetch, inst_fault, exp_pc, inst_of(exp_pc));
        end
        exp_pc += 32'd4; ndeliv++;
      end
    end
    checks++; if (ndeliv !== 10) begin errors++; $display("FAIL stream_count: got %0d want 10", ndeliv); end
  endtask

  task automatic test_full();
    arready = 1'b1; inst_ready = 1'b0; resp_en = 1'b1; fault_en = 1'b0;
    do_reset();
    repeat (10) tick();
    checks++; if (hs_total !== 4) begin errors++; $display("FAIL full_ars: got %0d want 4", hs_total); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL full_arvalid: got %b want 0", arvalid); end
    checks++; if (inst_valid !== 1'b1 || PC_now !== RST_PC) begin errors++; $display("FAIL full_head: got %b/%h want 1/%h", inst_valid, PC_now, RST_PC); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++; if (PC_now !== RST_PC + 32'd4) begin errors++; $display("FAIL full_pop: got %h want %h", PC_now, RST_PC + 32'd4); end
    repeat (6) tick();
    checks++; if (hs_total !== 5) begin errors++; $display("FAIL full_refill: got %0d want 5", hs_total); end
    checks++; if (last_hs_addr !== RST_PC + 32'h10) begin errors++; $display("FAIL full_refill_addr: got %h want %h", last_hs_addr, RST_PC + 32'h10); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL full_stop: got %b want 0", arvalid); end
  endtask

  task automatic test_jump_inflight();
    logic seen_ar, seen_v;
    arready = 1'b1; inst_ready = 1'b1; resp_en = 1'b0; fault_en = 1'b0;
    do_reset();
    repeat (3) tick();
    Jump_flag = 1'b1; Jump_PC = JPC;
    tick();
    Jump_flag = 1'b0; resp_en = 1'b1;
    checks++; if (hs_total !== 3) begin errors++; $display("FAIL jmp_inflight: got %0d want 3", hs_total); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL jmp_arvalid: got %b want 0", arvalid); end
    seen_ar = 1'b0; seen_v = 1'b0;
    for (int i = 0; i < 20 && !seen_v; i++) begin
      tick();
      if (arvalid && !seen_ar) begin
        seen_ar = 1'b1;
        checks++; if (PC_to_sram !== JPC) begin errors++; $display("FAIL jmp_first_ar: got %h want %h", PC_to_sram, JPC); end
      end
      if (inst_valid) begin
        seen_v = 1'b1;
        checks++; if (PC_now !== JPC || inst_fetch !== inst_of(JPC)) begin errors++; $display("FAIL jmp_first_inst: got %h/%h want %h/%h", PC_now, inst_fetch, JPC, inst_of(JPC)); end
      end
    end
    checks++; if (!seen_v) begin errors++; $display("FAIL jmp_timeout: got no inst_valid want one"); end
  endtask

  task automatic test_jump_pending();
    logic seen_v;
    arready = 1'b0; inst_ready = 1'b1; resp_en = 1'b1; fault_en = 1'b0;
    do_reset();
    repeat (2) tick();
    Jump_flag = 1'b1; Jump_PC = JPC;
    tick();
    Jump_flag = 1'b0;
    checks++; if (arvalid !== 1'b1 || PC_to_sram !== RST_PC) begin errors++; $display("FAIL pend_hold: got %b/%h want 1/%h", arvalid, PC_to_sram, RST_PC); end
    tick();
    checks++; if (arvalid !== 1'b1 || PC_to_sram !== RST_PC) begin errors++; $display("FAIL pend_hold2: got %b/%h want 1/%h", arvalid, PC_to_sram, RST_PC); end
    arready = 1'b1;
    tick();
    checks++; if (arvalid !== 1'b1 || PC_to_sram !== JPC) begin errors++; $display("FAIL pend_next_ar: got %b/%h want 1/%h", arvalid, PC_to_sram, JPC); end
    seen_v = 1'b0;
    for (int i = 0; i < 10 && !seen_v; i++) begin
      tick();
      if (inst_valid) begin
        seen_v = 1'b1;
        checks++; if (PC_now !== JPC) begin errors++; $display("FAIL pend_first_inst: got %h want %h", PC_now, JPC); end
      end
    end
    checks++; if (!seen_v) begin errors++; $display("FAIL pend_timeout: got no inst_valid want one"); end
  endtask

  task automatic test_fault();
    logic [31:0] exp_pc;
    int ndeliv;
    logic ar_seen;
    arready = 1'b1; inst_ready = 1'b1; resp_en = 1'b1;
    fault_en = 1'b1; fault_addr = RST_PC + 32'd8;
    do_reset();
    exp_pc = RST_PC; ndeliv = 0; ar_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i >= 8 && arvalid) ar_seen = 1'b1;
      if (inst_valid) begin
        checks++;
        if (PC_now !== exp_pc) begin errors++; $display("FAIL fault_pc: got %h want %h", PC_now, exp_pc); end
        if (exp_pc == fault_addr) begin
          checks++; if (inst_fault !== 1'b1 || inst_fetch !== NOP) begin errors++; $display("FAIL fault_entry: got %b/%h want 1/%h", inst_fault, inst_fetch, NOP); end
        end else begin
          checks++; if (inst_fault !== 1'b0 || inst_fetch !== inst_of(exp_pc)) begin errors++; $display("FAIL fault_good: got %b/%h want 0/%h", inst_fault, inst_fetch, inst_of(exp_pc)); end
        end
        exp_pc += 32'd4; ndeliv++;
      end
    end
    checks++; if (ndeliv !== 3) begin errors++; $display("FAIL fault_deliv: got %0d want 3", ndeliv); end
    checks++; if (hs_total !== 4) begin errors++; $display("FAIL fault_ars: got %0d want 4", hs_total); end
    checks++; if (ar_seen !== 1'b0) begin errors++; $display("FAIL fault_halt: got %b want 0", ar_seen); end
    fault_en = 1'b0;
    Jump_flag = 1'b1; Jump_PC = 32'h80002000;
    tick();
    Jump_flag = 1'b0;
    tick();
    checks++; if (arvalid !== 1'b1 || PC_to_sram !== 32'h80002000) begin errors++; $display("FAIL fault_resume: got %b/%h want 1/80002000", arvalid, PC_to_sram); end
  endtask

  task automatic test_reset_midflight();
    logic seen_v;
    arready = 1'b1; inst_ready = 1'b0; resp_en = 1'b1; fault_en = 1'b0;
    do_reset();
    repeat (4) tick();
    checks++; if (hs_total !== 3 || inst_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: got %0d/%b want 3/1", hs_total, inst_valid); end
    rst_n = 1'b0; rvalid = 1'b0; rq.delete();
    #1;
    checks++;
    if (arvalid !== 1'b0 || PC_to_sram !== RST_PC || inst_valid !== 1'b0 || inst_fetch !== NOP || PC_now !== RST_PC || inst_fault !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got %b/%h/%b/%h/%h/%b want 0/%h/0/%h/%h/0", arvalid, PC_to_sram, inst_valid, inst_fetch, PC_now, inst_fault, RST_PC, NOP, RST_PC);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; hs_total = 0; inst_ready = 1'b1;
    tick();
    checks++; if (arvalid !== 1'b1 || PC_to_sram !== RST_PC) begin errors++; $display("FAIL mid_restart: got %b/%h want 1/%h", arvalid, PC_to_sram, RST_PC); end
    seen_v = 1'b0;
    for (int i = 0; i < 6 && !seen_v; i++) begin
      tick();
      if (inst_valid) begin
        seen_v = 1'b1;
        checks++; if (PC_now !== RST_PC) begin errors++; $display("FAIL mid_first_inst: got %h want %h", PC_now, RST_PC); end
      end
    end
    checks++; if (!seen_v) begin errors++; $display("FAIL mid_timeout: got no inst_valid want one"); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_jump_inflight();
    test_jump_pending();
    test_fault();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
